// File: rtl/pio_out_handshake_pkg.sv
// Shared definitions for the handshaked output PIO: register map, bit indices
// and the handshake state encoding.
package pio_out_handshake_pkg;

  localparam int unsigned ADDR_WIDTH = 3;
  localparam int unsigned BUS_WIDTH  = 32;

  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = 3'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CONTROL = 3'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT   = 3'd3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_SET     = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLEAR   = 3'd5;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_OVR_BIT  = 1;
  localparam int unsigned CTRL_HS_EN_BIT  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } hs_state_e;

endpackage

// File: rtl/pio_out_handshake_hs_ctrl.sv
// Handshake sequencer: decides whether an update may land in the data register,
// tracks the pending word, counts completed transfers and flags overruns.
module pio_hs_ctrl
  import pio_out_handshake_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 update,
  input  logic                 hs_en,
  input  logic                 out_ready,
  input  logic                 ovr_clr,
  output logic                 accept_update,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overrun
);

  hs_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overrun_q, overrun_d;

  // Next-state logic; dropping hs_en aborts a pending word without counting it.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    overrun_d     = overrun_q;
    accept_update = 1'b0;

    if (ovr_clr) overrun_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (update) begin
          accept_update = 1'b1;
          if (hs_en) state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (update) overrun_d = 1'b1;
        if (!hs_en) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == ST_PEND);
  assign count     = count_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/pio_out_handshake.sv
// Avalon-MM output PIO with optional valid/ready handshake, SET/CLEAR aliases,
// status and completed-transfer counter readback.
module pio_out_handshake
  import pio_out_handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic                  wr_en;
  logic                  update;
  logic                  accept_update;
  logic                  ovr_clr;
  logic                  overrun;
  logic                  hs_valid;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] data_q, data_d, data_new;
  logic                  hs_en_q, hs_en_d;
  logic [31:0]           readdata_q, readdata_d;

  assign wr_en = chipselect & ~write_n;

  // Write decode: candidate data value plus control/status side effects.
  always_comb begin
    update   = 1'b0;
    ovr_clr  = 1'b0;
    data_new = data_q;
    hs_en_d  = hs_en_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          update   = 1'b1;
          data_new = DATA_WIDTH'(writedata);
        end
        ADDR_SET: begin
          update   = 1'b1;
          data_new = data_q | DATA_WIDTH'(writedata);
        end
        ADDR_CLEAR: begin
          update   = 1'b1;
          data_new = data_q & ~DATA_WIDTH'(writedata);
        end
        ADDR_STATUS:  ovr_clr = writedata[STATUS_OVR_BIT];
        ADDR_CONTROL: hs_en_d = writedata[CTRL_HS_EN_BIT];
        default: ;
      endcase
    end
  end

  // The sequencer sees the incoming hs_en so a disable takes effect on its write edge.
  pio_hs_ctrl #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctrl (
    .clk           (clk),
    .reset_n       (reset_n),
    .update        (update),
    .hs_en         (hs_en_d),
    .out_ready     (out_ready),
    .ovr_clr       (ovr_clr),
    .accept_update (accept_update),
    .out_valid     (hs_valid),
    .count         (count),
    .overrun       (overrun)
  );

  always_comb begin
    data_d = accept_update ? data_new : data_q;
  end

  // Read mux; sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d = 32'(data_q);
      ADDR_STATUS: begin
        readdata_d[STATUS_BUSY_BIT] = hs_valid;
        readdata_d[STATUS_OVR_BIT]  = overrun;
      end
      ADDR_CONTROL: readdata_d[CTRL_HS_EN_BIT] = hs_en_q;
      ADDR_COUNT:   readdata_d = 32'(count);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= DATA_WIDTH'(RESET_VALUE);
      hs_en_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      hs_en_q    <= hs_en_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign out_port  = data_q;
  assign out_valid = hs_valid;

endmodule

// File: doc/pio_out_handshake.md
Name: pio_out_handshake

Overview:
- Avalon-MM memory-mapped output PIO. The HPS/processor writes a 32-bit word, and the block drives it onto `out_port` for the FPGA fabric.
- An optional valid/ready handshake tells the fabric when a new word has arrived. It is the write-side counterpart of the team's read-only input PIOs.
- Status and a completed-transfer counter can be read back over the same slave, with 1-cycle registered read latency.

Parameters:
- DATA_WIDTH, 32, width of `out_port` and the data register (1..32); unused readdata bits read 0.
- RESET_VALUE, 0, value loaded into the data register at reset.
- CNT_WIDTH, 16, width of the completed-transfer counter (≤32).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- out_port  out  DATA_WIDTH  current data register to the fabric.
- out_valid  out  1  new word pending; handshake mode only.
- out_ready  in  1  fabric accepts the pending word.

Behaviour:

Register map (word addresses):
- 0 DATA (R/W): read returns the data register.
- 1 STATUS:
  - bit0 BUSY (RO) = `out_valid`.
  - bit1 OVERRUN (sticky, write-1-to-clear).
- 2 CONTROL (R/W): bit0 HS_EN. Other bits read 0.
- 3 COUNT (RO): completed-handshake counter, zero-extended.
- 4 SET (WO): data |= writedata.
- 5 CLEAR (WO): data &= ~writedata.
- 6, 7, and reads of 4/5 return 0. Writes to RO/unused addresses have no effect.

Reset (asynchronous, reset_n=0):
- data = RESET_VALUE, so out_port = RESET_VALUE.
- out_valid = 0, OVERRUN = 0, HS_EN = 0, COUNT = 0, readdata = 0.
- Reset mid-handshake aborts the transfer with no count increment.

Read path:
- readdata updates every clk with the mux output for the current address.
- Value appears 1 cycle after address is presented; reads have no side effects.

"Update" = a write to DATA, SET or CLEAR.

HS_EN=0 (plain mode):
- An update changes the data register on the clock edge of the write; out_port reflects it the next cycle.
- out_valid stays 0; COUNT and OVERRUN are unaffected.

HS_EN=1, state machine IDLE/PEND:
- IDLE + update → data register updated, state PEND, out_valid=1 from the next cycle.
- PEND + out_ready=1 → IDLE next cycle, out_valid=0, COUNT += 1.
- PEND + update → data register unchanged (write dropped), OVERRUN=1.
  - This applies even if out_ready=1 in the same cycle; the state still goes to IDLE.
- out_port is stable for the whole time out_valid=1.

Handshake enable changes:
- Clearing HS_EN while in PEND → IDLE next cycle, out_valid=0, no COUNT increment.
- Setting HS_EN does not itself raise out_valid.

Counter and status rules:
- COUNT wraps from 2^CNT_WIDTH−1 to 0.
- STATUS write with bit1=1 clears OVERRUN. If a new overrun occurs in the same cycle, set wins.
- out_valid is a registered output with no combinational path from out_ready.

Decomposition:
- Shared package holds:
  - register address constants ADDR_DATA..ADDR_CLEAR;
  - STATUS/CONTROL bit-index constants;
  - the state enum {ST_IDLE, ST_PEND}.
- Sub-module `pio_hs_ctrl`: the IDLE/PEND FSM, COUNT and OVERRUN logic. Inputs: update strobe, hs_en, out_ready, ovr_clr. Outputs: accept_update, out_valid, count, overrun.
- The top level keeps the register file, SET/CLEAR arithmetic and read mux.

Test Plan:
1. Reset with RESET_VALUE=0xA5 → out_port=0xA5, out_valid=0, all reads 0 except DATA=0xA5; reading address 0 gives 0xA5 one cycle after address is presented.
2. HS_EN=0; write DATA=0x1234, SET 0xF0000, CLEAR 0x4 → out_port=0x1234, then 0xF1234, then 0xF1230; out_valid never 1; COUNT=0.
3. HS_EN=1; write DATA=0x55, hold out_ready=0 for 5 cycles, then pulse 1 → out_valid high exactly from write+1 until the cycle after the ready pulse; out_port=0x55 throughout; COUNT=1.
4. HS_EN=1; write 0x11, then write 0x22 while PEND (with out_ready=1 in the same cycle) → out_port stays 0x11, OVERRUN=1, COUNT=1. Writing STATUS 0x2 → OVERRUN=0.
5. Preload COUNT to 0xFFFF via 65535 handshakes (or force), one more handshake → COUNT reads 0.
6. HS_EN=1, write 0x77, then write CONTROL=0 while PEND → out_valid=0 next cycle, COUNT unchanged. Separately, assert reset_n=0 mid-PEND → out_valid=0 immediately, out_port=RESET_VALUE.
